central_sirene: RTL

Sequential alarm annunciator at the receiving end of the factory-alarm request line. It takes the combinational `sirene_req` level from the end-of-shift alarm logic, filters it, and latches an alarm. It drives a pulsed buzzer and a steady alarm LED until a guard acknowledges, then applies a timed mute with automatic re-arm. It sits between the alarm-condition logic and the board LEDs, all in the `clk_2` domain.

---
 rtl/central_sirene.sv | 113 +++++++++++
 1 files changed

// File: rtl/central_sirene.sv
// Alarm annunciator: filters sirene_req, latches the alarm, pulses the buzzer until ack, then applies a timed mute with re-arm.
// Outputs are registered; a trigger takes N_FILTRO consecutive high samples; there is no backpressure, inputs are sampled every cycle.
module central_sirene #(
  parameter int N_FILTRO       = 3,
  parameter int PERIODO_BIP    = 4,
  parameter int TEMPO_SILENCIO = 16,
  parameter int NBITS_CONT     = 8
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  sirene_req,
  input  logic                  ack,
  output logic                  buzzer,
  output logic                  led_alarme,
  output logic [1:0]            estado,
  output logic [NBITS_CONT-1:0] eventos
);

  localparam int W_FILTRO = $clog2(N_FILTRO + 1);
  localparam int W_FASE   = (PERIODO_BIP > 1) ? $clog2(PERIODO_BIP) : 1;
  localparam int W_TIMER  = (TEMPO_SILENCIO > 1) ? $clog2(TEMPO_SILENCIO) : 1;

  localparam logic [W_FILTRO-1:0] FILTRO_MAX = W_FILTRO'(N_FILTRO);
  localparam logic [W_FILTRO-1:0] FILTRO_LIM = W_FILTRO'(N_FILTRO - 1);
  localparam logic [W_FASE-1:0]   FASE_MAX   = W_FASE'(PERIODO_BIP - 1);
  localparam logic [W_TIMER-1:0]  TIMER_MAX  = W_TIMER'(TEMPO_SILENCIO - 1);

  typedef enum logic [1:0] {
    REPOUSO     = 2'b00,
    DISPARADO   = 2'b01,
    RECONHECIDO = 2'b10,
    ILEGAL      = 2'b11
  } estado_t;

  estado_t               est_q;
  estado_t               est_d;
  logic [W_FILTRO-1:0]   cnt_filtro;
  logic [W_FASE-1:0]     fase;
  logic [W_TIMER-1:0]    timer;
  logic                  ack_q;
  logic                  req_ok;
  logic                  ack_rise;
  logic                  entra_disp;
  logic                  entra_rec;

  // cnt_filtro+1 >= N_FILTRO rewritten as cnt_filtro >= N_FILTRO-1 to stay in the counter width
  assign req_ok   = sirene_req && (cnt_filtro >= FILTRO_LIM);
  assign ack_rise = ack && !ack_q;
  assign estado   = est_q;

  always_comb begin
    est_d = REPOUSO;
    case (est_q)
      REPOUSO:     est_d = req_ok ? DISPARADO : REPOUSO;
      DISPARADO:   est_d = ack_rise ? RECONHECIDO : DISPARADO;
      RECONHECIDO: begin
        if (!sirene_req)             est_d = REPOUSO;
        else if (timer == TIMER_MAX) est_d = DISPARADO;
        else                         est_d = RECONHECIDO;
      end
      default:     est_d = REPOUSO;
    endcase
    entra_disp = (est_d == DISPARADO) && (est_q != DISPARADO);
    entra_rec  = (est_d == RECONHECIDO) && (est_q != RECONHECIDO);
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      est_q      <= REPOUSO;
      cnt_filtro <= '0;
      fase       <= '0;
      timer      <= '0;
      ack_q      <= 1'b0;
      buzzer     <= 1'b0;
      led_alarme <= 1'b0;
      eventos    <= '0;
    end else begin
      est_q      <= est_d;
      ack_q      <= ack;
      led_alarme <= (est_d == DISPARADO) || (est_d == RECONHECIDO);

      if (!sirene_req)
        cnt_filtro <= '0;
      else if (cnt_filtro != FILTRO_MAX)
        cnt_filtro <= cnt_filtro + 1'b1;

      // Buzzer restarts high on every entry, including re-triggers after the mute
      if (est_d == DISPARADO) begin
        if (entra_disp) begin
          buzzer <= 1'b1;
          fase   <= '0;
        end else if (fase == FASE_MAX) begin
          buzzer <= ~buzzer;
          fase   <= '0;
        end else begin
          fase <= fase + 1'b1;
        end
      end else begin
        buzzer <= 1'b0;
        fase   <= '0;
      end

      if (entra_rec)
        timer <= '0;
      else if (est_d == RECONHECIDO)
        timer <= timer + 1'b1;

      if (entra_disp && (eventos != '1))
        eventos <= eventos + 1'b1;
    end
  end

endmodule
